// File: rtl/phys_mem_arbiter_pkg.sv
// Shared types and constants for the physical memory port arbiter.
// Holds the ownership state encoding, the credit counter width and the latched request layout.
package phys_mem_arbiter_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_write;
  } mem_req_t;

endpackage

// File: rtl/phys_mem_arbiter.sv
// Shares the physical memory controller port between the CPU (default owner, zero-latency mux)
// and one secondary master that is granted whole transfers, rate-limited by a CPU credit counter.
module phys_mem_arbiter
  import phys_mem_arbiter_pkg::*;
#(
  parameter int unsigned CPU_SLOTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_is_write_i,
  input  logic        cpu_lock_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_busy_o,
  input  logic        dma_req_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic        dma_is_write_i,
  output logic        dma_ack_o,
  output logic [31:0] dma_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_is_write_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_busy_i
);

  arb_state_e          state_q;
  logic [CREDIT_W-1:0] credit_q;
  mem_req_t            dma_lat_q;
  logic                dma_ack_q;
  logic [31:0]         dma_rdata_q;
  logic                grant_s;

  // Only hand the port over at a clean boundary: CPU idle-safe, credit spent, previous ack retired.
  assign grant_s = (state_q == S_CPU) && dma_req_i && !mem_busy_i && !cpu_is_write_i
                   && !cpu_lock_i && (credit_q == '0) && !dma_ack_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CPU;
      credit_q    <= '0;
      dma_lat_q   <= '0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= 32'h0000_0000;
    end else begin
      dma_ack_q <= 1'b0;
      case (state_q)
        S_CPU: begin
          if (grant_s) begin
            state_q   <= S_DMA;
            dma_lat_q <= '{addr: dma_addr_i, wdata: dma_wdata_i, is_write: dma_is_write_i};
          end else if (!mem_busy_i && (credit_q != '0)) begin
            credit_q <= credit_q - CREDIT_W'(1);
          end
        end
        S_DMA: begin
          if (!mem_busy_i) begin
            state_q     <= S_CPU;
            dma_ack_q   <= 1'b1;
            dma_rdata_q <= mem_rdata_i;
            credit_q    <= CREDIT_W'(CPU_SLOTS);
          end
        end
        default: state_q <= S_CPU;
      endcase
    end
  end

  always_comb begin
    cpu_rdata_o = mem_rdata_i;
    if (state_q == S_DMA) begin
      mem_addr_o     = dma_lat_q.addr;
      mem_wdata_o    = dma_lat_q.wdata;
      mem_is_write_o = dma_lat_q.is_write;
      cpu_busy_o     = 1'b1;
    end else begin
      mem_addr_o     = cpu_addr_i;
      mem_wdata_o    = cpu_wdata_i;
      mem_is_write_o = cpu_is_write_i;
      cpu_busy_o     = mem_busy_i;
    end
  end

  assign dma_ack_o   = dma_ack_q;
  assign dma_rdata_o = dma_rdata_q;

endmodule
